// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the exhaustive gate sweep checker: gate op codes
// and the sweep state encoding.
package gate_sweep_pkg;

  // Gate select codes; reduction ops over all gate inputs.
  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MAX  = 3'd4;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden reference for an N-input gate: maps (op, vec) to the
// bit a correct gate of that kind must produce.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N_INPUTS = 2
) (
  input  logic [2:0]          op,
  input  logic [N_INPUTS-1:0] vec,
  output logic                expected
);

  // Reduction of the input vector according to the selected gate op.
  always_comb begin
    expected = 1'b0;
    case (op)
      OP_NAND: expected = ~(&vec);
      OP_NOR:  expected = ~(|vec);
      OP_AND:  expected = &vec;
      OP_OR:   expected = |vec;
      OP_XOR:  expected = ^vec;
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus engine and self-checker for an N-input logic gate.
// Walks every input vector, holds each for HOLD_CYCLES clocks, samples the
// gate output on the last hold clock and accumulates mismatch results.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N_INPUTS    = 2,
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W       = N_INPUTS + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic                dut_y,
  output logic [N_INPUTS-1:0] stim,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    err_count,
  output logic [N_INPUTS-1:0] first_fail_vec,
  output logic                first_fail_valid,
  output logic                bad_op
);

  // Hold counter needs at least one bit even when every cycle samples.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  // vec carries one spare MSB so the terminal vector never aliases to 0.
  localparam logic [N_INPUTS:0] VEC_LAST = {1'b0, {N_INPUTS{1'b1}}};
  localparam logic [N_INPUTS:0] VEC_ONE  = (N_INPUTS + 1)'(1);
  localparam logic [CNT_W-1:0]  ERR_ONE  = CNT_W'(1);

  state_t              state_r, state_s;
  logic [2:0]          op_r, op_s;
  logic [N_INPUTS:0]   vec_r, vec_s;
  logic [N_INPUTS:0]   vec_inc_s;
  logic [HOLD_W-1:0]   hold_r, hold_s;
  logic [N_INPUTS-1:0] stim_r, stim_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                pass_r, pass_s;
  logic [CNT_W-1:0]    err_r, err_s;
  logic [N_INPUTS-1:0] ffv_r, ffv_s;
  logic                ffvalid_r, ffvalid_s;
  logic                bad_op_r, bad_op_s;
  logic                expected_s;
  logic                mismatch_s;

  gate_ref_model #(
    .N_INPUTS (N_INPUTS)
  ) u_ref (
    .op       (op_r),
    .vec      (vec_r[N_INPUTS-1:0]),
    .expected (expected_s)
  );

  assign vec_inc_s = vec_r + VEC_ONE;

  // Case-inequality flags X/Z from the gate as a mismatch in simulation;
  // in hardware this reduces to an XOR of the two bits.
  always_comb begin
    mismatch_s = (dut_y !== expected_s);
  end

  // Next-state, counter and result-register update logic.
  always_comb begin
    state_s   = state_r;
    op_s      = op_r;
    vec_s     = vec_r;
    hold_s    = hold_r;
    stim_s    = stim_r;
    busy_s    = busy_r;
    done_s    = done_r;
    pass_s    = pass_r;
    err_s     = err_r;
    ffv_s     = ffv_r;
    ffvalid_s = ffvalid_r;
    bad_op_s  = 1'b0;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (op <= OP_MAX) begin
            state_s   = ST_DRIVE;
            op_s      = op;
            vec_s     = {(N_INPUTS + 1){1'b0}};
            hold_s    = {HOLD_W{1'b0}};
            stim_s    = {N_INPUTS{1'b0}};
            busy_s    = 1'b1;
            done_s    = 1'b0;
            pass_s    = 1'b0;
            err_s     = {CNT_W{1'b0}};
            ffv_s     = {N_INPUTS{1'b0}};
            ffvalid_s = 1'b0;
          end else begin
            // Unknown op: flag it and keep whatever results are on show.
            bad_op_s = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end

      ST_DRIVE: begin
        if (hold_r == HOLD_LAST) begin
          if (mismatch_s) begin
            err_s = err_r + ERR_ONE;
            if (!ffvalid_r) begin
              ffv_s     = vec_r[N_INPUTS-1:0];
              ffvalid_s = 1'b1;
            end else begin
              ffvalid_s = ffvalid_r;
            end
          end else begin
            err_s = err_r;
          end

          if (vec_r == VEC_LAST) begin
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (err_s == {CNT_W{1'b0}});
          end else begin
            vec_s  = vec_inc_s;
            hold_s = {HOLD_W{1'b0}};
            stim_s = vec_inc_s[N_INPUTS-1:0];
          end
        end else begin
          hold_s = hold_r + HOLD_ONE;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        pass_s    = 1'b0;
        stim_s    = {N_INPUTS{1'b0}};
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      op_r      <= 3'd0;
      vec_r     <= {(N_INPUTS + 1){1'b0}};
      hold_r    <= {HOLD_W{1'b0}};
      stim_r    <= {N_INPUTS{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      err_r     <= {CNT_W{1'b0}};
      ffv_r     <= {N_INPUTS{1'b0}};
      ffvalid_r <= 1'b0;
      bad_op_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      op_r      <= op_s;
      vec_r     <= vec_s;
      hold_r    <= hold_s;
      stim_r    <= stim_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      pass_r    <= pass_s;
      err_r     <= err_s;
      ffv_r     <= ffv_s;
      ffvalid_r <= ffvalid_s;
      bad_op_r  <= bad_op_s;
    end
  end

  assign stim             = stim_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_r;
  assign first_fail_vec   = ffv_r;
  assign first_fail_valid = ffvalid_r;
  assign bad_op           = bad_op_r;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (N=2/HOLD=10 and N=3/HOLD=1)
// each driving a gate modelled as a truth table, checked against expected
// sweep results computed directly from the gate definitions.
module tb_gate_sweep_checker;

  localparam int NA = 2;
  localparam int HA = 10;
  localparam int NB = 3;
  localparam int HB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          start_a, dut_y_a, busy_a, done_a, pass_a, ffok_a, bad_a;
  logic [2:0]    op_a;
  logic [NA-1:0] stim_a, ffv_a;
  logic [NA:0]   err_a;
  logic [3:0]    tt_a;

  logic          start_b, dut_y_b, busy_b, done_b, pass_b, ffok_b, bad_b;
  logic [2:0]    op_b;
  logic [NB-1:0] stim_b, ffv_b;
  logic [NB:0]   err_b;
  logic [7:0]    tt_b;

  // Gates under test: arbitrary truth tables indexed by the stimulus.
  assign dut_y_a = tt_a[stim_a];
  assign dut_y_b = tt_b[stim_b];

  gate_sweep_checker #(.N_INPUTS(NA), .HOLD_CYCLES(HA), .CNT_W(NA + 1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .op(op_a), .dut_y(dut_y_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail_vec(ffv_a), .first_fail_valid(ffok_a),
    .bad_op(bad_a)
  );

  gate_sweep_checker #(.N_INPUTS(NB), .HOLD_CYCLES(HB), .CNT_W(NB + 1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .op(op_b), .dut_y(dut_y_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail_vec(ffv_b), .first_fail_valid(ffok_b),
    .bad_op(bad_b)
  );

  int n_vec = 0;
  int n_bad = 0;
  int last_err [2];
  int last_pass[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Gate definitions straight from their names.
  function automatic logic ref_bit(input int op, input int v, input int n);
    int all1 = (1 << n) - 1;
    case (op)
      0:       return (v != all1);
      1:       return (v == 0);
      2:       return (v == all1);
      3:       return (v != 0);
      default: return ($countones(v) % 2) == 1;
    endcase
  endfunction

  function automatic logic [7:0] good_table(input int op, input int n);
    logic [7:0] t = 8'h00;
    for (int v = 0; v < (1 << n); v++) t[v] = ref_bit(op, v, n);
    return t;
  endfunction

  function automatic logic [31:0] o_stim(input bit sel); return sel ? 32'(stim_b) : 32'(stim_a); endfunction
  function automatic logic [31:0] o_busy(input bit sel); return sel ? 32'(busy_b) : 32'(busy_a); endfunction
  function automatic logic [31:0] o_done(input bit sel); return sel ? 32'(done_b) : 32'(done_a); endfunction
  function automatic logic [31:0] o_pass(input bit sel); return sel ? 32'(pass_b) : 32'(pass_a); endfunction
  function automatic logic [31:0] o_err (input bit sel); return sel ? 32'(err_b)  : 32'(err_a);  endfunction
  function automatic logic [31:0] o_ffv (input bit sel); return sel ? 32'(ffv_b)  : 32'(ffv_a);  endfunction
  function automatic logic [31:0] o_ffok(input bit sel); return sel ? 32'(ffok_b) : 32'(ffok_a); endfunction
  function automatic logic [31:0] o_bad (input bit sel); return sel ? 32'(bad_b)  : 32'(bad_a);  endfunction

  task automatic drive(input bit sel, input logic s, input logic [2:0] op);
    if (sel) begin start_b = s; op_b = op; end
    else     begin start_a = s; op_a = op; end
  endtask

  task automatic set_tt(input bit sel, input logic [7:0] t);
    if (sel) tt_b = t;
    else     tt_a = t[3:0];
  endtask

  task automatic check_all_zero(input bit sel);
    check("rst_stim", o_stim(sel), 0);
    check("rst_busy", o_busy(sel), 0);
    check("rst_done", o_done(sel), 0);
    check("rst_pass", o_pass(sel), 0);
    check("rst_err",  o_err(sel),  0);
    check("rst_ffv",  o_ffv(sel),  0);
    check("rst_ffok", o_ffok(sel), 0);
    check("rst_bad",  o_bad(sel),  0);
  endtask

  // One full sweep; optional start pulse mid-sweep must be ignored.
  task automatic run_sweep(input bit sel, input int op, input logic [7:0] tt, input bit poke);
    int n     = sel ? NB : NA;
    int h     = sel ? HB : HA;
    int total = (1 << n) * h;
    int exp_err = 0;
    int first = -1;
    int idx = 0;
    bit walk_ok = 1'b1;
    for (int v = 0; v < (1 << n); v++) begin
      if (tt[v] != ref_bit(op, v, n)) begin
        exp_err++;
        if (first < 0) first = v;
      end
    end
    @(negedge clk);
    set_tt(sel, tt);
    drive(sel, 1'b1, 3'(op));
    @(negedge clk);
    drive(sel, 1'b0, 3'($urandom_range(0, 7)));
    while (o_done(sel) == 0 && idx < total + 20) begin
      if (o_stim(sel) != 32'(idx / h) || o_busy(sel) != 1) walk_ok = 1'b0;
      if (poke && idx == 3) drive(sel, 1'b1, 3'($urandom_range(0, 4)));
      else if (poke && idx == 4) drive(sel, 1'b0, 3'($urandom_range(0, 7)));
      @(negedge clk);
      idx++;
    end
    check("sweep_len",        idx, total);
    check("stim_walk",        32'(walk_ok), 1);
    check("busy_end",         o_busy(sel), 0);
    check("stim_hold",        o_stim(sel), (1 << n) - 1);
    check("err_count",        o_err(sel), exp_err);
    check("first_fail_valid", o_ffok(sel), 32'(exp_err > 0));
    check("first_fail_vec",   o_ffv(sel), (first < 0) ? 0 : first);
    check("pass",             o_pass(sel), 32'(exp_err == 0));
    last_err[sel]  = exp_err;
    last_pass[sel] = (exp_err == 0) ? 1 : 0;
  endtask

  // Start with an illegal op: one-cycle bad_op, no state change.
  task automatic bad_op_test(input bit sel, input bit in_done);
    @(negedge clk);
    drive(sel, 1'b1, 3'd6);
    @(negedge clk);
    drive(sel, 1'b0, 3'd0);
    check("bad_op_hi",   o_bad(sel),  1);
    check("bad_op_busy", o_busy(sel), 0);
    check("bad_op_done", o_done(sel), 32'(in_done));
    check("bad_op_err",  o_err(sel),  last_err[sel]);
    check("bad_op_pass", o_pass(sel), last_pass[sel]);
    @(negedge clk);
    check("bad_op_lo",   o_bad(sel),  0);
    check("bad_op_busy2", o_busy(sel), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    rst = 1'b1;
    start_a = 1'b0; op_a = 3'd0; tt_a = 4'h0;
    start_b = 1'b0; op_b = 3'd0; tt_b = 8'h00;
    last_err[0] = 0; last_err[1] = 0; last_pass[0] = 0; last_pass[1] = 0;
    repeat (3) @(negedge clk);
    check_all_zero(1'b0);
    check_all_zero(1'b1);
    rst = 1'b0;

    bad_op_test(1'b0, 1'b0);
    run_sweep(1'b0, 0, good_table(0, NA), 1'b1);     // correct NAND
    bad_op_test(1'b0, 1'b1);
    run_sweep(1'b0, 0, 8'h0F, 1'b0);                 // stuck-at-1
    run_sweep(1'b0, 4, good_table(0, NA), 1'b0);     // XOR vs NAND
    bad_op_test(1'b0, 1'b1);
    run_sweep(1'b1, 1, good_table(1, NB), 1'b1);     // fast NOR
    bad_op_test(1'b1, 1'b1);

    // Reset mid-sweep discards partial results.
    @(negedge clk);
    set_tt(1'b0, good_table(0, NA));
    drive(1'b0, 1'b1, 3'd4);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0);
    wait_cnt = 0;
    while (stim_a != 2'b10 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("mid_reached", 32'(wait_cnt < 100), 1);
    check("mid_err", o_err(1'b0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero(1'b0);
    last_err[0] = 0; last_pass[0] = 0;

    // Randomised sweeps on both geometries.
    for (int k = 0; k < 12; k++) begin
      bit sel = 1'($urandom_range(0, 1));
      int op = $urandom_range(0, 4);
      logic [7:0] tt = ($urandom_range(0, 1) == 1) ? good_table(op, sel ? NB : NA) : 8'($urandom);
      run_sweep(sel, op, tt, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
